alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked ALU built as the next generation of the team's 16-bit clocked ALU.
- Adds configurable datapath width, full-width multiply (high half output), divide with remainder, and a divide-by-zero indication.
- MUL and DIV run as iterative multi-cycle engines, one bit per cycle; all other operations complete in one cycle.
- Sits between the register file/decoder (upstream, valid/ready) and writeback (downstream, valid/ready with backpressure).

Parameters:
- WIDTH, 16, operand and result width in bits (must be ≥ 2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- IN_VALID  input  1  operation request valid.
- IN_READY  output  1  block can accept a request.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALU_FUN  input  4  opcode (encoding below).
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts result.
- ALU_OUT  output  WIDTH  primary result.
- ALU_OUT_HI  output  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder; otherwise 0.
- Carry_Flag  output  1  ADD carry-out / SUB borrow / shifted-out bit.
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  output  1 each  operation class of the current result.
- Div_Zero_Flag  output  1  DIV issued with B == 0.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV (unsigned).
  - 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR.
  - 10 CMPEQ (result 1 if A==B, else 0), 11 CMPG (2 if A>B, else 0), 12 CMPL (3 if A<B, else 0).
  - 13 SHR (logical right by 1), 14 SHL (left by 1), 15 reserved.
- Reset (RST low, asynchronous):
  - State goes to IDLE, IN_READY=1, OUT_VALID=0.
  - ALU_OUT, ALU_OUT_HI, all flags and internal operand/counter registers are cleared to 0.
  - Reset asserted mid-MUL/DIV aborts the operation; no result is produced.
- FSM states IDLE, BUSY, DONE:
  - IDLE: IN_READY=1. IN_VALID is sampled high → A, B and ALU_FUN are captured.
    - MUL, or DIV with B≠0: load the engine and go to BUSY.
    - All other opcodes (including DIV with B==0): compute the result into the output registers and go to DONE.
  - BUSY: IN_READY=0. Perform exactly WIDTH iterations (counter WIDTH-1 down to 0), then write the outputs and go to DONE.
  - DONE: OUT_VALID=1, IN_READY=0. Outputs are held stable until OUT_READY=1, then go to IDLE with OUT_VALID=0.
  - No new request is accepted in the same cycle as the result handshake.
- Latency, counting the acceptance edge as cycle 0:
  - Single-cycle ops: OUT_VALID high from cycle 1.
  - MUL/DIV: OUT_VALID high from cycle WIDTH+1.
  - Maximum throughput: one op per 2 cycles (single-cycle ops) or per WIDTH+2 cycles (MUL/DIV).
- MUL: unsigned shift-add. The full 2*WIDTH product is split as {ALU_OUT_HI, ALU_OUT}. Carry_Flag=0.
- DIV: unsigned restoring division. ALU_OUT = quotient, ALU_OUT_HI = remainder.
- DIV with B==0: ALU_OUT=0, ALU_OUT_HI=A, Div_Zero_Flag=1, Arith_Flag=1, single-cycle latency.
- ADD: {Carry_Flag, ALU_OUT} = A+B in WIDTH+1 bits.
- SUB: ALU_OUT = A−B modulo 2^WIDTH; Carry_Flag=1 iff A<B (borrow).
- Shifts: SHR sets Carry_Flag=A[0]; SHL sets Carry_Flag=A[WIDTH-1]. Zero fill in both cases.
- Class flags:
  - Exactly one of Arith/Logic/CMP/Shift is 1 for opcodes 0–14.
  - Opcode 15 produces ALU_OUT=0, ALU_OUT_HI=0 and all flags 0, but still completes the handshake.
- All outputs are registered. Flags and results change only on entry to DONE or on reset.

Test Plan:
- WIDTH=16: ADD A=0xFFFF, B=0x0001 → OUT_VALID at cycle 1, ALU_OUT=0x0000, Carry_Flag=1, Arith_Flag=1, other class flags 0.
- MUL A=0x1234, B=0x5678 → OUT_VALID exactly at cycle 17, ALU_OUT=0x0060, ALU_OUT_HI=0x0626; IN_READY=0 during cycles 1–17.
- DIV A=1000, B=7 → ALU_OUT=142, ALU_OUT_HI=6 at cycle 17. DIV A=0x00AB, B=0 → cycle 1: ALU_OUT=0, ALU_OUT_HI=0x00AB, Div_Zero_Flag=1.
- Backpressure: SUB A=3, B=5 with OUT_READY=0 for 5 cycles → ALU_OUT=0xFFFE, Carry_Flag=1 held stable; A/B changed meanwhile must not affect outputs; IN_READY returns the cycle after OUT_READY=1.
- Reset mid-MUL: drop RST at cycle 8 → all outputs 0 immediately (asynchronous), IN_READY=1 after release, no spurious OUT_VALID.
- Sweep: CMPG A=9, B=4 → 2, CMP_Flag=1; SHL A=0x8001 → 0x0002, Carry_Flag=1; opcode 15 → 0 with all flags 0. Rerun MUL/DIV with WIDTH=8 and WIDTH=32 against a reference model.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/compare/shift ops plus iterative
// unsigned multiply and restoring divide, one bit per cycle.
//
// state  | meaning
// S_IDLE | ready for a request; single-cycle ops resolve on acceptance
// S_BUSY | MUL/DIV engine iterating, WIDTH steps
// S_DONE | result valid, held until downstream takes it
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] ALU_OUT_HI,
  output logic             Carry_Flag,
  output logic             Arith_Flag,
  output logic             Logic_Flag,
  output logic             CMP_Flag,
  output logic             Shift_Flag,
  output logic             Div_Zero_Flag
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL  = 4'd2,  OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_NAND = 4'd6,  OP_NOR  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8,  OP_XNOR = 4'd9, OP_CMPEQ = 4'd10, OP_CMPG = 4'd11;
  localparam logic [3:0] OP_CMPL = 4'd12, OP_SHR = 4'd13, OP_SHL  = 4'd14;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_div;
  logic [WIDTH-1:0] op_b, acc_lo, acc_hi;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] sc_lo, sc_hi;
  logic             sc_carry, sc_arith, sc_logic, sc_cmp, sc_shift, sc_dz;
  logic             start_engine;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};
  assign start_engine = (ALU_FUN == OP_MUL) || ((ALU_FUN == OP_DIV) && (B != '0));

  always_comb begin
    sc_lo = '0; sc_hi = '0; sc_carry = 1'b0;
    sc_arith = 1'b0; sc_logic = 1'b0; sc_cmp = 1'b0; sc_shift = 1'b0; sc_dz = 1'b0;
    case (ALU_FUN)
      OP_ADD:   begin sc_lo = sum[WIDTH-1:0];  sc_carry = sum[WIDTH];  sc_arith = 1'b1; end
      OP_SUB:   begin sc_lo = diff[WIDTH-1:0]; sc_carry = diff[WIDTH]; sc_arith = 1'b1; end
      // only reached with B == 0; nonzero divisors go to the engine
      OP_DIV:   begin sc_hi = A; sc_arith = 1'b1; sc_dz = 1'b1; end
      OP_AND:   begin sc_lo = A & B;    sc_logic = 1'b1; end
      OP_OR:    begin sc_lo = A | B;    sc_logic = 1'b1; end
      OP_NAND:  begin sc_lo = ~(A & B); sc_logic = 1'b1; end
      OP_NOR:   begin sc_lo = ~(A | B); sc_logic = 1'b1; end
      OP_XOR:   begin sc_lo = A ^ B;    sc_logic = 1'b1; end
      OP_XNOR:  begin sc_lo = ~(A ^ B); sc_logic = 1'b1; end
      OP_CMPEQ: begin sc_lo = (A == B) ? WIDTH'(1) : '0; sc_cmp = 1'b1; end
      OP_CMPG:  begin sc_lo = (A > B)  ? WIDTH'(2) : '0; sc_cmp = 1'b1; end
      OP_CMPL:  begin sc_lo = (A < B)  ? WIDTH'(3) : '0; sc_cmp = 1'b1; end
      OP_SHR:   begin sc_lo = {1'b0, A[WIDTH-1:1]}; sc_carry = A[0];       sc_shift = 1'b1; end
      OP_SHL:   begin sc_lo = {A[WIDTH-2:0], 1'b0}; sc_carry = A[WIDTH-1]; sc_shift = 1'b1; end
      default:  ;
    endcase
  end

  // One iteration of each engine; {acc_hi, acc_lo} is the product or {remainder, quotient}
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff, step_lo, step_hi;
  logic             div_ge;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, op_b};
  assign div_diff  = div_shift[WIDTH-1:0] - op_b;
  assign step_lo   = op_div ? {acc_lo[WIDTH-2:0], div_ge} : {mul_sum[0], acc_lo[WIDTH-1:1]};
  assign step_hi   = op_div ? (div_ge ? div_diff : div_shift[WIDTH-1:0]) : mul_sum[WIDTH:1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE; cnt <= '0; op_div <= 1'b0;
      op_b <= '0; acc_lo <= '0; acc_hi <= '0;
      IN_READY <= 1'b1; OUT_VALID <= 1'b0;
      ALU_OUT <= '0; ALU_OUT_HI <= '0;
      Carry_Flag <= 1'b0; Arith_Flag <= 1'b0; Logic_Flag <= 1'b0;
      CMP_Flag <= 1'b0; Shift_Flag <= 1'b0; Div_Zero_Flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (IN_VALID) begin
          IN_READY <= 1'b0;
          if (start_engine) begin
            acc_lo <= A; acc_hi <= '0; op_b <= B;
            op_div <= (ALU_FUN == OP_DIV);
            cnt    <= CNT_LAST;
            state  <= S_BUSY;
          end else begin
            ALU_OUT <= sc_lo; ALU_OUT_HI <= sc_hi;
            Carry_Flag <= sc_carry; Arith_Flag <= sc_arith; Logic_Flag <= sc_logic;
            CMP_Flag <= sc_cmp; Shift_Flag <= sc_shift; Div_Zero_Flag <= sc_dz;
            OUT_VALID <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_BUSY: begin
          acc_lo <= step_lo; acc_hi <= step_hi;
          if (cnt == '0) begin
            ALU_OUT <= step_lo; ALU_OUT_HI <= step_hi;
            Carry_Flag <= 1'b0; Arith_Flag <= 1'b1; Logic_Flag <= 1'b0;
            CMP_Flag <= 1'b0; Shift_Flag <= 1'b0; Div_Zero_Flag <= 1'b0;
            OUT_VALID <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: if (OUT_READY) begin
          OUT_VALID <= 1'b0;
          IN_READY  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 16-bit vector table, backpressure and reset
// sequences, and MUL/DIV at 8 and 32 bits against a wide-arithmetic model.
module tb_alu_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST;

  logic        in_valid, out_ready, in_ready, out_valid;
  logic [3:0]  alu_fun;
  logic [15:0] a, b, alu_out, alu_out_hi;
  wire  [5:0]  fl16;

  logic        w_valid, w_ready, in_ready8, out_valid8, in_ready32, out_valid32;
  logic [3:0]  w_fun;
  logic [7:0]  a8, b8, out8, hi8;
  logic [31:0] a32, b32, out32, hi32;
  wire  [5:0]  fl8, fl32;

  alu_seq #(.WIDTH(16)) u16 (
    .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_READY(in_ready), .A(a), .B(b),
    .ALU_FUN(alu_fun), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .ALU_OUT(alu_out), .ALU_OUT_HI(alu_out_hi),
    .Carry_Flag(fl16[5]), .Arith_Flag(fl16[4]), .Logic_Flag(fl16[3]),
    .CMP_Flag(fl16[2]), .Shift_Flag(fl16[1]), .Div_Zero_Flag(fl16[0]));

  alu_seq #(.WIDTH(8)) u8 (
    .CLK(CLK), .RST(RST), .IN_VALID(w_valid), .IN_READY(in_ready8), .A(a8), .B(b8),
    .ALU_FUN(w_fun), .OUT_VALID(out_valid8), .OUT_READY(w_ready),
    .ALU_OUT(out8), .ALU_OUT_HI(hi8),
    .Carry_Flag(fl8[5]), .Arith_Flag(fl8[4]), .Logic_Flag(fl8[3]),
    .CMP_Flag(fl8[2]), .Shift_Flag(fl8[1]), .Div_Zero_Flag(fl8[0]));

  alu_seq #(.WIDTH(32)) u32 (
    .CLK(CLK), .RST(RST), .IN_VALID(w_valid), .IN_READY(in_ready32), .A(a32), .B(b32),
    .ALU_FUN(w_fun), .OUT_VALID(out_valid32), .OUT_READY(w_ready),
    .ALU_OUT(out32), .ALU_OUT_HI(hi32),
    .Carry_Flag(fl32[5]), .Arith_Flag(fl32[4]), .Logic_Flag(fl32[3]),
    .CMP_Flag(fl32[2]), .Shift_Flag(fl32[1]), .Div_Zero_Flag(fl32[0]));

  // flags packed as {Carry, Arith, Logic, CMP, Shift, Div_Zero}
  typedef struct {
    logic [3:0]  fun;
    logic [15:0] a, b, lo, hi;
    logic [5:0]  fl;
    int          lat;
  } vec_t;

  vec_t vt[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] fun, input logic [15:0] va, vb, lo, hi,
                         input logic [5:0] fl, input int lat);
    vec_t v;
    v.fun = fun; v.a = va; v.b = vb; v.lo = lo; v.hi = hi; v.fl = fl; v.lat = lat;
    vt.push_back(v);
  endtask

  // Issue one request on the 16-bit DUT and wait (bounded) for OUT_VALID.
  task automatic run16(input logic [3:0] fun, input logic [15:0] va, vb,
                       output logic [15:0] lo, hi, output logic [5:0] fl,
                       output int lat, output int rdy_bad);
    int k = 0;
    while (!in_ready && k < 50) begin @(negedge CLK); k++; end
    chk("in_ready_before_req", in_ready, 1);
    in_valid = 1'b1; alu_fun = fun; a = va; b = vb;
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 1; rdy_bad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_bad++;
      @(negedge CLK);
      lat++;
    end
    if (in_ready) rdy_bad++;
    lo = alu_out; hi = alu_out_hi; fl = fl16;
  endtask

  task automatic ack16();
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  // Same request to the 8- and 32-bit DUTs; model uses plain wide arithmetic.
  task automatic run_wide(input logic [3:0] fun, input logic [31:0] va, vb);
    int l8 = 0, l32 = 0;
    logic [7:0]  c8_lo = '0, c8_hi = '0, e8_lo, e8_hi;
    logic [31:0] c32_lo = '0, c32_hi = '0, e32_lo, e32_hi;
    logic [15:0] p8;
    logic [63:0] p32;
    w_fun = fun; a32 = va; b32 = vb; a8 = va[7:0]; b8 = vb[7:0];
    w_valid = 1'b1;
    @(negedge CLK);
    w_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (out_valid8 && l8 == 0) begin l8 = c; c8_lo = out8; c8_hi = hi8; end
      if (out_valid32 && l32 == 0) begin l32 = c; c32_lo = out32; c32_hi = hi32; end
      if (l8 != 0 && l32 != 0) break;
      @(negedge CLK);
    end
    if (fun == 4'd2) begin
      p8 = {8'h00, a8} * {8'h00, b8};
      p32 = {32'h0, a32} * {32'h0, b32};
      e8_lo = p8[7:0]; e8_hi = p8[15:8];
      e32_lo = p32[31:0]; e32_hi = p32[63:32];
    end else begin
      e8_lo = a8 / b8; e8_hi = a8 % b8;
      e32_lo = a32 / b32; e32_hi = a32 % b32;
    end
    chk($sformatf("w8_fun%0d_lat", fun), l8, 9);
    chk($sformatf("w8_fun%0d_lo", fun), c8_lo, e8_lo);
    chk($sformatf("w8_fun%0d_hi", fun), c8_hi, e8_hi);
    chk($sformatf("w32_fun%0d_lat", fun), l32, 33);
    chk($sformatf("w32_fun%0d_lo", fun), c32_lo, e32_lo);
    chk($sformatf("w32_fun%0d_hi", fun), c32_hi, e32_hi);
    w_ready = 1'b1;
    @(negedge CLK);
    w_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] lo, hi;
    logic [5:0]  fl;
    int lat, rdy_bad, spurious;

    RST = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; alu_fun = '0; a = '0; b = '0;
    w_valid = 1'b0; w_ready = 1'b0; w_fun = '0; a8 = '0; b8 = '0; a32 = '0; b32 = '0;

    add_vec(4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 6'b110000, 1);
    add_vec(4'd2,  16'h1234, 16'h5678, 16'h0060, 16'h0626, 6'b010000, 17);
    add_vec(4'd3,  16'd1000, 16'd7,    16'd142,  16'd6,    6'b010000, 17);
    add_vec(4'd3,  16'h00AB, 16'h0000, 16'h0000, 16'h00AB, 6'b010001, 1);
    add_vec(4'd11, 16'd9,    16'd4,    16'd2,    16'h0000, 6'b000100, 1);
    add_vec(4'd14, 16'h8001, 16'h0000, 16'h0002, 16'h0000, 6'b100010, 1);
    add_vec(4'd15, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 6'b000000, 1);
    add_vec(4'd1,  16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 6'b110000, 1);
    add_vec(4'd1,  16'h0005, 16'h0003, 16'h0002, 16'h0000, 6'b010000, 1);
    add_vec(4'd0,  16'h1234, 16'h1111, 16'h2345, 16'h0000, 6'b010000, 1);
    add_vec(4'd4,  16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 6'b001000, 1);
    add_vec(4'd5,  16'h1200, 16'h0034, 16'h1234, 16'h0000, 6'b001000, 1);
    add_vec(4'd6,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 6'b001000, 1);
    add_vec(4'd7,  16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 6'b001000, 1);
    add_vec(4'd8,  16'h00FF, 16'h0F0F, 16'h0FF0, 16'h0000, 6'b001000, 1);
    add_vec(4'd9,  16'h00FF, 16'h0F0F, 16'hF00F, 16'h0000, 6'b001000, 1);
    add_vec(4'd10, 16'd5,    16'd5,    16'd1,    16'h0000, 6'b000100, 1);
    add_vec(4'd10, 16'd5,    16'd6,    16'd0,    16'h0000, 6'b000100, 1);
    add_vec(4'd11, 16'd4,    16'd9,    16'd0,    16'h0000, 6'b000100, 1);
    add_vec(4'd12, 16'd4,    16'd9,    16'd3,    16'h0000, 6'b000100, 1);
    add_vec(4'd12, 16'd9,    16'd4,    16'd0,    16'h0000, 6'b000100, 1);
    add_vec(4'd13, 16'h0003, 16'h0000, 16'h0001, 16'h0000, 6'b100010, 1);
    add_vec(4'd13, 16'h8000, 16'h0000, 16'h4000, 16'h0000, 6'b000010, 1);
    add_vec(4'd2,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 6'b010000, 17);
    add_vec(4'd3,  16'd5,    16'd9,    16'd0,    16'd5,    6'b010000, 17);
    add_vec(4'd3,  16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 6'b010000, 17);

    repeat (3) @(negedge CLK);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_alu_out_hi", alu_out_hi, 0);
    chk("rst_flags", fl16, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    foreach (vt[i]) begin
      run16(vt[i].fun, vt[i].a, vt[i].b, lo, hi, fl, lat, rdy_bad);
      chk($sformatf("v%0d_op%0d_lo", i, vt[i].fun), lo, vt[i].lo);
      chk($sformatf("v%0d_op%0d_hi", i, vt[i].fun), hi, vt[i].hi);
      chk($sformatf("v%0d_op%0d_flags", i, vt[i].fun), fl, vt[i].fl);
      chk($sformatf("v%0d_op%0d_latency", i, vt[i].fun), lat, vt[i].lat);
      chk($sformatf("v%0d_op%0d_in_ready_low", i, vt[i].fun), rdy_bad, 0);
      ack16();
    end

    // Backpressure: result must hold while operands wiggle
    run16(4'd1, 16'd3, 16'd5, lo, hi, fl, lat, rdy_bad);
    chk("bp_lo", lo, 16'hFFFE);
    chk("bp_latency", lat, 1);
    for (int k = 0; k < 5; k++) begin
      a = 16'(k * 16'h1111); b = 16'hA5A5 ^ 16'(k);
      @(negedge CLK);
      chk($sformatf("bp_hold%0d_lo", k), alu_out, 16'hFFFE);
      chk($sformatf("bp_hold%0d_carry", k), fl16[5], 1);
      chk($sformatf("bp_hold%0d_valid", k), out_valid, 1);
      chk($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
    end
    ack16();
    chk("bp_in_ready_back", in_ready, 1);
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_lo_after_ack", alu_out, 16'hFFFE);

    // Reset mid-MUL: leave a nonzero result first so the clear is visible
    run16(4'd7, 16'h0000, 16'h0000, lo, hi, fl, lat, rdy_bad);
    ack16();
    in_valid = 1'b1; alu_fun = 4'd2; a = 16'h1234; b = 16'h5678;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (7) @(negedge CLK);
    chk("mr_busy_in_ready", in_ready, 0);
    chk("mr_prev_lo", alu_out, 16'hFFFF);
    RST = 1'b0;
    #1;
    chk("mr_async_lo", alu_out, 0);
    chk("mr_async_hi", alu_out_hi, 0);
    chk("mr_async_flags", fl16, 0);
    chk("mr_async_valid", out_valid, 0);
    chk("mr_async_in_ready", in_ready, 1);
    @(negedge CLK);
    RST = 1'b1;
    spurious = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLK);
      if (out_valid) spurious++;
    end
    chk("mr_no_spurious_valid", spurious, 0);
    chk("mr_in_ready_idle", in_ready, 1);
    run16(4'd0, 16'd1, 16'd2, lo, hi, fl, lat, rdy_bad);
    chk("mr_recover_lo", lo, 16'd3);
    ack16();

    run_wide(4'd2, 32'hDEADBEEF, 32'h12345678);
    run_wide(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_wide(4'd2, 32'h00000003, 32'h80000001);
    run_wide(4'd3, 32'hDEADBEEF, 32'h00001234);
    run_wide(4'd3, 32'hFFFFFFFF, 32'h00000007);
    run_wide(4'd3, 32'h00000005, 32'h0000FF09);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
